// File: rtl/gs_update_unit_pkg.sv
// Shared widths and constants for the Gauss-Seidel update path and its register file.
package gs_pkg;
  localparam int X_W      = 32;
  localparam int B_W      = 16;
  localparam int ACC_W    = 40;
  localparam int RECIP    = 3277;
  localparam int N_UNK    = 16;
  localparam int ITER_NUM = 16;
  localparam int FRAC_W   = 16;
  localparam int IDX_W    = 4;
  localparam int SWP_W    = 5;
endpackage

// File: rtl/gs_update_unit_if.sv
// Operand/result bundle between the x/b register file and the update datapath.
interface gs_update_unit_if;
  import gs_pkg::*;

  logic                    start_in;
  logic                    valid_in;
  logic signed [B_W-1:0]   b_in;
  logic signed [X_W-1:0]   x1_in;
  logic signed [X_W-1:0]   x2_in;
  logic signed [X_W-1:0]   x3_in;
  logic signed [X_W-1:0]   x4_in;
  logic signed [X_W-1:0]   x5_in;
  logic signed [X_W-1:0]   x6_in;
  logic                    valid_out;
  logic signed [X_W-1:0]   x_out;
  logic [IDX_W-1:0]        idx_out;
  logic [SWP_W-1:0]        sweep_out;
  logic                    done_out;

  modport master (
    output start_in, valid_in, b_in, x1_in, x2_in, x3_in, x4_in, x5_in, x6_in,
    input  valid_out, x_out, idx_out, sweep_out, done_out
  );

  modport slave (
    input  start_in, valid_in, b_in, x1_in, x2_in, x3_in, x4_in, x5_in, x6_in,
    output valid_out, x_out, idx_out, sweep_out, done_out
  );
endinterface

// File: rtl/gs_update_unit_sat_round.sv
// Divide-by-20 back end: multiply by the Q0.16 reciprocal, round half up,
// drop the fraction bits and saturate into a Q16.16 word.
module gs_sat_round
  import gs_pkg::*;
(
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [X_W-1:0]   x_o
);
  // Reciprocal is 13 bits signed, so this width holds any accumulator product.
  localparam int PROD_W = ACC_W + 14;

  localparam logic signed [PROD_W-1:0] RECIP_P = PROD_W'(RECIP);
  localparam logic signed [PROD_W-1:0] HALF_P  = PROD_W'(1) <<< (FRAC_W - 1);
  localparam logic signed [PROD_W-1:0] MAX_V   = (PROD_W'(1) <<< (X_W - 1)) - PROD_W'(1);
  localparam logic signed [PROD_W-1:0] MIN_V   = -(PROD_W'(1) <<< (X_W - 1));

  function automatic logic signed [PROD_W-1:0] round_shift(input logic signed [ACC_W-1:0] a);
    logic signed [PROD_W-1:0] ext;
    logic signed [PROD_W-1:0] prod;
    ext  = {{(PROD_W-ACC_W){a[ACC_W-1]}}, a};
    prod = (ext * RECIP_P) + HALF_P;
    return prod >>> FRAC_W;
  endfunction

  function automatic logic signed [X_W-1:0] saturate(input logic signed [PROD_W-1:0] q);
    if (q > MAX_V)      return MAX_V[X_W-1:0];
    else if (q < MIN_V) return MIN_V[X_W-1:0];
    else                return q[X_W-1:0];
  endfunction

  assign x_o = saturate(round_shift(acc_i));
endmodule

// File: rtl/gs_update_unit.sv
// Three-stage Gauss-Seidel row update with row/sweep tracking and completion flag.
module gs_update_unit
  import gs_pkg::*;
(
  input  logic           clk_in,
  input  logic           rst_n_in,
  gs_update_unit_if.slave gif
);
  logic                        vld_p0_q, vld_p0_d;
  logic                        vld_p1_q, vld_p1_d;
  logic                        valid_out_q, valid_out_d;
  logic signed [X_W:0]         sum1_p0_q, sum1_p0_d;
  logic signed [X_W:0]         sum2_p0_q, sum2_p0_d;
  logic signed [X_W:0]         sum3_p0_q, sum3_p0_d;
  logic signed [B_W+FRAC_W-1:0] bq_p0_q, bq_p0_d;
  logic signed [ACC_W-1:0]     acc_p1_q, acc_p1_d;
  logic signed [X_W-1:0]       x_out_q, x_out_d;
  logic signed [X_W-1:0]       x_rnd;
  logic [IDX_W-1:0]            idx_cnt_q, idx_cnt_d;
  logic [IDX_W-1:0]            idx_out_q, idx_out_d;
  logic [SWP_W-1:0]            sweep_q, sweep_d;
  logic                        done_q, done_d;
  logic                        accept;
  logic                        out_fire;
  logic signed [ACC_W-1:0]     e1, e2, e3, eb;

  // Stage 1: pairwise neighbour sums and b promoted to Q16.16
  always_comb begin
    accept    = gif.valid_in & ~done_q & ~gif.start_in;
    vld_p0_d  = accept;
    sum1_p0_d = sum1_p0_q;
    sum2_p0_d = sum2_p0_q;
    sum3_p0_d = sum3_p0_q;
    bq_p0_d   = bq_p0_q;
    if (accept) begin
      sum1_p0_d = $signed({gif.x1_in[X_W-1], gif.x1_in}) + $signed({gif.x2_in[X_W-1], gif.x2_in});
      sum2_p0_d = $signed({gif.x3_in[X_W-1], gif.x3_in}) + $signed({gif.x4_in[X_W-1], gif.x4_in});
      sum3_p0_d = $signed({gif.x5_in[X_W-1], gif.x5_in}) + $signed({gif.x6_in[X_W-1], gif.x6_in});
      bq_p0_d   = {gif.b_in, {FRAC_W{1'b0}}};
    end
  end

  // Stage 2: weighted accumulation using shift-add constant multiplies
  assign e1 = {{(ACC_W-X_W-1){sum1_p0_q[X_W]}}, sum1_p0_q};
  assign e2 = {{(ACC_W-X_W-1){sum2_p0_q[X_W]}}, sum2_p0_q};
  assign e3 = {{(ACC_W-X_W-1){sum3_p0_q[X_W]}}, sum3_p0_q};
  assign eb = {{(ACC_W-B_W-FRAC_W){bq_p0_q[B_W+FRAC_W-1]}}, bq_p0_q};

  always_comb begin
    vld_p1_d = vld_p0_q & ~gif.start_in;
    acc_p1_d = acc_p1_q;
    if (vld_p0_q)
      acc_p1_d = eb + (e1 <<< 3) + (e1 <<< 2) + e1 - ((e2 <<< 2) + (e2 <<< 1)) + e3;
  end

  // Stage 3: divide, round, saturate; row/sweep bookkeeping rides with the result
  gs_sat_round u_sat_round (
    .acc_i (acc_p1_q),
    .x_o   (x_rnd)
  );

  always_comb begin
    out_fire    = vld_p1_q & ~done_q & ~gif.start_in;
    valid_out_d = out_fire;
    x_out_d     = x_out_q;
    idx_out_d   = idx_out_q;
    idx_cnt_d   = idx_cnt_q;
    sweep_d     = sweep_q;
    done_d      = done_q;
    if (gif.start_in) begin
      idx_out_d = '0;
      idx_cnt_d = '0;
      sweep_d   = '0;
      done_d    = 1'b0;
    end else if (out_fire) begin
      x_out_d   = x_rnd;
      idx_out_d = idx_cnt_q;
      idx_cnt_d = idx_cnt_q + IDX_W'(1);
      if (idx_cnt_q == IDX_W'(N_UNK - 1)) begin
        idx_cnt_d = '0;
        sweep_d   = sweep_q + SWP_W'(1);
        if (sweep_q == SWP_W'(ITER_NUM - 1))
          done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld_p0_q    <= 1'b0;
      vld_p1_q    <= 1'b0;
      valid_out_q <= 1'b0;
      sum1_p0_q   <= '0;
      sum2_p0_q   <= '0;
      sum3_p0_q   <= '0;
      bq_p0_q     <= '0;
      acc_p1_q    <= '0;
      x_out_q     <= '0;
      idx_cnt_q   <= '0;
      idx_out_q   <= '0;
      sweep_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      vld_p0_q    <= vld_p0_d;
      vld_p1_q    <= vld_p1_d;
      valid_out_q <= valid_out_d;
      sum1_p0_q   <= sum1_p0_d;
      sum2_p0_q   <= sum2_p0_d;
      sum3_p0_q   <= sum3_p0_d;
      bq_p0_q     <= bq_p0_d;
      acc_p1_q    <= acc_p1_d;
      x_out_q     <= x_out_d;
      idx_cnt_q   <= idx_cnt_d;
      idx_out_q   <= idx_out_d;
      sweep_q     <= sweep_d;
      done_q      <= done_d;
    end
  end

  assign gif.valid_out = valid_out_q;
  assign gif.x_out     = x_out_q;
  assign gif.idx_out   = idx_out_q;
  assign gif.sweep_out = sweep_q;
  assign gif.done_out  = done_q;
endmodule

// File: tb/tb_gs_update_unit.sv
// Directed bench for gs_update_unit: arithmetic corners, sweep counting, start and async reset.
module tb_gs_update_unit;
  import gs_pkg::*;

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b0;
  int   n_chk    = 0;
  int   n_err    = 0;

  gs_update_unit_if gif();

  gs_update_unit dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .gif      (gif)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    gif.start_in = 1'b0;
    gif.valid_in = 1'b0;
    gif.b_in     = '0;
    gif.x1_in    = '0;
    gif.x2_in    = '0;
    gif.x3_in    = '0;
    gif.x4_in    = '0;
    gif.x5_in    = '0;
    gif.x6_in    = '0;
  endtask

  task automatic set_op(input logic [15:0] b, input logic [31:0] x1, input logic [31:0] x2,
                        input logic [31:0] x3, input logic [31:0] x4,
                        input logic [31:0] x5, input logic [31:0] x6);
    gif.valid_in = 1'b1;
    gif.b_in     = b;
    gif.x1_in    = x1;
    gif.x2_in    = x2;
    gif.x3_in    = x3;
    gif.x4_in    = x4;
    gif.x5_in    = x5;
    gif.x6_in    = x6;
  endtask

  // One isolated set: checks the two bubble cycles, then the result at latency 3.
  task automatic run_one(input string tag, input logic [15:0] b,
                         input logic [31:0] x1, input logic [31:0] x2,
                         input logic [31:0] x3, input logic [31:0] x4,
                         input logic [31:0] x5, input logic [31:0] x6,
                         input logic [31:0] exp_x, input logic [31:0] exp_idx);
    set_op(b, x1, x2, x3, x4, x5, x6);
    tick();
    gif.valid_in = 1'b0;
    chk({tag, "_lat1"}, 32'(gif.valid_out), 32'd0);
    tick();
    chk({tag, "_lat2"}, 32'(gif.valid_out), 32'd0);
    tick();
    chk({tag, "_vld"}, 32'(gif.valid_out), 32'd1);
    chk({tag, "_x"}, gif.x_out, exp_x);
    chk({tag, "_idx"}, 32'(gif.idx_out), exp_idx);
  endtask

  initial begin
    int outs;
    int extra;
    bit seen;

    idle_inputs();
    rst_n_in = 1'b0;
    repeat (2) tick();
    chk("rst_vld",   32'(gif.valid_out), 32'd0);
    chk("rst_x",     gif.x_out,          32'd0);
    chk("rst_idx",   32'(gif.idx_out),   32'd0);
    chk("rst_sweep", 32'(gif.sweep_out), 32'd0);
    chk("rst_done",  32'(gif.done_out),  32'd0);
    rst_n_in = 1'b1;
    tick();

    run_one("t1_b20",   16'd20, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0001_0004, 32'd0);
    run_one("t2_x12",   16'd0, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h0, 32'h0, 32'h0,
            32'h0001_4CD2, 32'd1);
    run_one("t3_x34",   16'd0, 32'h0, 32'h0, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h0,
            32'hFFFF_6664, 32'd2);
    run_one("t4_satp",  16'h7FFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0,
            32'h7FFF_FFFF, 32'd3);
    run_one("t4_satn",  16'h8000, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0, 32'h0, 32'h0,
            32'h8000_0000, 32'd4);

    // start with two sets in flight and a third offered in the same cycle
    set_op(16'd0, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    tick();
    gif.start_in = 1'b1;
    tick();
    gif.start_in = 1'b0;
    gif.valid_in = 1'b0;
    chk("t6_vld0",  32'(gif.valid_out), 32'd0);
    chk("t6_idx",   32'(gif.idx_out),   32'd0);
    chk("t6_sweep", 32'(gif.sweep_out), 32'd0);
    chk("t6_done",  32'(gif.done_out),  32'd0);
    tick();
    chk("t6_vld1", 32'(gif.valid_out), 32'd0);
    tick();
    chk("t6_vld2", 32'(gif.valid_out), 32'd0);
    run_one("t6_next", 16'd0, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h0, 32'h0, 32'h0,
            32'h0001_4CD2, 32'd0);

    // full run of ITER_NUM sweeps, back to back
    gif.start_in = 1'b1;
    tick();
    gif.start_in = 1'b0;
    set_op(16'd20, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    outs = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (gif.valid_out) begin
        outs++;
        chk("t5_x",     gif.x_out,          32'h0001_0004);
        chk("t5_idx",   32'(gif.idx_out),   32'((outs - 1) % 16));
        chk("t5_sweep", 32'(gif.sweep_out), 32'(outs / 16));
        chk("t5_done",  32'(gif.done_out),  32'(outs == 256));
      end
    end
    chk("t5_count",     32'(outs),          32'd256);
    chk("t5_done_end",  32'(gif.done_out),  32'd1);
    chk("t5_sweep_end", 32'(gif.sweep_out), 32'd16);
    extra = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (gif.valid_out) extra++;
    end
    chk("t5_no_more", 32'(extra), 32'd0);

    // asynchronous reset between clock edges while done is set
    #2;
    rst_n_in = 1'b0;
    #1;
    chk("t7_done_async",  32'(gif.done_out),  32'd0);
    chk("t7_sweep_async", 32'(gif.sweep_out), 32'd0);
    rst_n_in = 1'b1;
    set_op(16'd20, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (!seen) begin
        tick();
        if (gif.valid_out) seen = 1'b1;
      end
    end
    chk("t7_stream", 32'(seen), 32'd1);
    #2;
    rst_n_in = 1'b0;
    #1;
    chk("t7_vld_async", 32'(gif.valid_out), 32'd0);
    chk("t7_x_async",   gif.x_out,          32'd0);
    chk("t7_idx_async", 32'(gif.idx_out),   32'd0);
    idle_inputs();
    tick();
    rst_n_in = 1'b1;
    extra = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (gif.valid_out) extra++;
    end
    chk("t7_no_partial", 32'(extra), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
